// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU arbiter/scheduler.
//   op_e    : ALU opcode encoding (OP_ADD .. OP_DIV2)
//   state_e : scheduler FSM states
//   OPND_W  : operand width, RES_W : result width, CNT_W : EXEC counter width
package alu_pkg;

  localparam int OPND_W = 5;
  localparam int RES_W  = 10;
  localparam int CNT_W  = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_XOR  = 3'b100,
    OP_OR   = 3'b101,
    OP_MUL2 = 3'b110,
    OP_DIV2 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 5-bit ALU.
// Ports:
//   a, b   : unsigned operands (OPND_W bits)
//   op     : opcode
//   result : zero-extended RES_W-bit result
module alu_core
  import alu_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  op_e               op,
  output logic [RES_W-1:0]  result
);

  // Carry-out bit of add and borrow-wrap of sub both live in bit OPND_W.
  logic [OPND_W:0] sum;
  logic [OPND_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = RES_W'(sum);
      OP_SUB:  result = RES_W'(diff);
      OP_MUL:  result = RES_W'(a) * RES_W'(b);
      OP_AND:  result = RES_W'(a & b);
      OP_XOR:  result = RES_W'(a ^ b);
      OP_OR:   result = RES_W'(a | b);
      OP_MUL2: result = RES_W'({a, 1'b0});
      OP_DIV2: result = RES_W'(a >> 1);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arb_sched.sv
// Shares one ALU between two requesters: round-robin arbitration, multi-cycle
// execute (multiply stretched by MUL_LAT), tagged result on one response port.
// Optional feature macro: ALU_ARB_STATS_EN adds per-requester grant counters.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   req_valid/req_ready[1:0]  : request handshake per requester
//   req_a, req_b, req_op      : operands / opcode per requester
//   rsp_valid/rsp_ready       : response handshake
//   rsp_id, rsp_result        : owner and value of the result
//   busy                      : FSM not in IDLE
//   grant_cnt0/1              : (ALU_ARB_STATS_EN) accept counters, wrap at 16 bits
//
// state   | meaning
// IDLE    | arbitrate; accept one request if any is valid
// EXEC    | count down; register ALU result when counter is 0
// RESP    | hold result until rsp_ready
module alu_arb_sched
  import alu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][OPND_W-1:0] req_a,
  input  logic [1:0][OPND_W-1:0] req_b,
  input  logic [1:0][2:0]        req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [RES_W-1:0]       rsp_result,
  output logic                   busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]            grant_cnt0,
  output logic [15:0]            grant_cnt1
`endif
);

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;   // last granted requester
  logic [OPND_W-1:0]  a_q, a_d, b_q, b_d;
  op_e                op_q, op_d;
  logic               id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [RES_W-1:0]   alu_res;
  logic               gnt_id;

  alu_core u_alu_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    req_ready = '0;

    case (req_valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = ~ptr_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        // rst gating keeps req_ready at its reset value while reset is held.
        if (|req_valid && !rst) begin
          req_ready[gnt_id] = 1'b1;
          ptr_d   = gnt_id;
          id_d    = gnt_id;
          a_d     = req_a[gnt_id];
          b_d     = req_b[gnt_id];
          op_d    = op_e'(req_op[gnt_id]);
          cnt_d   = (op_e'(req_op[gnt_id]) == OP_MUL) ? CNT_W'(MUL_LAT) : '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          res_d   = alu_res;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [15:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d;

  always_comb begin
    gcnt0_d = gcnt0_q + 16'(req_ready[0]);
    gcnt1_d = gcnt1_q + 16'(req_ready[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
    end
  end

  assign grant_cnt0 = gcnt0_q;
  assign grant_cnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_alu_arb_sched.sv
// Self-checking bench for alu_arb_sched: directed scenarios plus random
// traffic, checked every cycle against a timing-level reference model.
module tb_alu_arb_sched;
  import alu_pkg::*;

  localparam int MUL_LAT = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][OPND_W-1:0] req_a;
  logic [1:0][OPND_W-1:0] req_b;
  logic [1:0][2:0]        req_op;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_id;
  logic [RES_W-1:0]       rsp_result;
  logic                   busy;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]            grant_cnt0, grant_cnt1;
`endif

  alu_arb_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_alu(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % 64;
      1: return (a - b + 64) % 64;
      2: return a * b;
      3: return a & b;
      4: return a ^ b;
      5: return a | b;
      6: return a * 2;
      default: return a / 2;
    endcase
  endfunction

  // Reference model: idle flag, last grant, cycle at which the response is due.
  bit m_idle;
  int m_last, m_due, m_res, m_id, cyc;
  int m_cnt [2];

  // Values observed in the most recent tick.
  int o_acc, o_cyc, o_res, o_id, o_rdy;
  bit o_rsp;

  task automatic model_reset();
    m_idle   = 1'b1;
    m_last   = 1;
    m_due    = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef ALU_ARB_STATS_EN
    chk({tag, "_cnt0"}, grant_cnt0, 0);
    chk({tag, "_cnt1"}, grant_cnt1, 0);
`endif
  endtask

  // One clock cycle: check at negedge, update model, return 1 after posedge.
  task automatic tick();
    int g;
    bit exp_rv, hs;
    @(negedge clk);
    g = -1;
    if (m_idle) begin
      case (req_valid)
        2'b01:   g = 0;
        2'b10:   g = 1;
        2'b11:   g = 1 - m_last;
        default: g = -1;
      endcase
    end
    exp_rv = !m_idle && (cyc >= m_due);
    chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    chk("busy", busy, !m_idle);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_res);
    end
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, m_cnt[0] & 32'hFFFF);
    chk("grant_cnt1", grant_cnt1, m_cnt[1] & 32'hFFFF);
`endif
    o_acc = g;
    o_cyc = cyc;
    o_rsp = rsp_valid;
    o_res = rsp_result;
    o_id  = rsp_id;
    o_rdy = req_ready;
    hs = exp_rv && rsp_ready;
    if (g >= 0) begin
      m_id   = g;
      m_res  = ref_alu(req_a[g], req_b[g], req_op[g]);
      m_due  = cyc + 2 + ((req_op[g] == 3'd2) ? MUL_LAT : 0);
      m_last = g;
      m_cnt[g]++;
      m_idle = 1'b0;
    end
    if (hs) m_idle = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_one(input int id, input int a, input int b, input int op,
                         input int exp_res, input int exp_lat, input string tag);
    int t_acc;
    bit acc;
    acc = 1'b0;
    t_acc = 0;
    rsp_ready     = 1'b1;
    req_valid     = '0;
    req_valid[id] = 1'b1;
    req_a[id]     = 5'(a);
    req_b[id]     = 5'(b);
    req_op[id]    = 3'(op);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!acc && o_acc == id) begin
        acc = 1'b1;
        t_acc = o_cyc;
        req_valid[id] = 1'b0;
      end else if (acc && o_rsp) begin
        chk({tag, "_lat"}, o_cyc - t_acc, exp_lat);
        chk({tag, "_res"}, o_res, exp_res);
        chk({tag, "_id"}, o_id, id);
        return;
      end
    end
    chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (req_valid == 2'b00 && m_idle) return;
      tick();
      for (int i = 0; i < 2; i++) if (o_acc == i) req_valid[i] = 1'b0;
    end
    chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int n, last_c;
    bit got;

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    cyc       = 0;
    model_reset();
    #12;
    check_reset("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) tick();

    // Directed single operations
    run_one(0, 7, 9, 0, 16, 2, "add");
    run_one(0, 3, 5, 1, 62, 2, "sub");
    run_one(1, 31, 31, 2, 961, 2 + MUL_LAT, "mul");
    drain();

    // Both requesters valid continuously
    req_a[0] = 5'd20; req_b[0] = 5'd0; req_op[0] = 3'd6;
    req_a[1] = 5'd11; req_b[1] = 5'd0; req_op[1] = 3'd6;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    n = 0;
    last_c = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      tick();
      if (o_acc >= 0) begin
        chk("rr_order", o_acc, n % 2);
        if (n > 0) chk("rr_space", o_cyc - last_c, 3);
        last_c = o_cyc;
        n++;
      end
      if (o_rsp) chk("rr_res", o_res, (o_id != 0) ? 22 : 40);
    end
    if (n < 4) chk("rr_timeout", n, 4);
    drain();

    // Backpressure
    rsp_ready = 1'b0;
    req_a[0] = 5'd17; req_b[0] = 5'd0; req_op[0] = 3'd7;
    req_valid = 2'b01;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (o_acc == 0) got = 1'b1;
    end
    if (!got) chk("bp_accept_timeout", 0, 1);
    req_valid = 2'b10;
    req_a[1] = 5'd1; req_b[1] = 5'd1; req_op[1] = 3'd0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", o_rsp, 1);
      chk("bp_res", o_res, 8);
      chk("bp_ready", o_rdy, 0);
    end
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("bp_next_acc", o_acc, 1);
    req_valid = 2'b00;
    drain();

    // Reset in the middle of a multiply
    req_a[1] = 5'd13; req_b[1] = 5'd6; req_op[1] = 3'd2;
    req_valid = 2'b10;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (o_acc == 1) got = 1'b1;
    end
    if (!got) chk("mr_accept_timeout", 0, 1);
    req_valid = 2'b00;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    @(negedge clk);
    check_reset("mid_rst_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 6; k++) tick();
    req_a[0] = 5'd2; req_b[0] = 5'd3; req_op[0] = 3'd0;
    req_a[1] = 5'd4; req_b[1] = 5'd5; req_op[1] = 3'd0;
    req_valid = 2'b11;
    tick();
    chk("post_rst_grant", o_acc, 0);
    drain();

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rsp_ready = ($urandom % 4) != 0;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && o_acc == i) req_valid[i] = 1'b0;
        if (!req_valid[i] && ($urandom % 3) == 0) begin
          req_valid[i] = 1'b1;
          req_a[i]     = 5'($urandom);
          req_b[i]     = 5'($urandom);
          req_op[i]    = 3'($urandom);
        end
      end
    end
    drain();
    for (int k = 0; k < 3; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arb_sched.md
# alu_arb_sched

Controller that shares one 5-bit ALU datapath (add, sub, mul, and, xor, or, ×2, ÷2; 10-bit result) between two requesters. Each requester presents an operation over a valid/ready handshake. A round-robin arbiter grants one request at a time, the block sequences it through a multi-cycle execute phase (multiply is stretched by a parameterised latency), and returns the tagged result over a single valid/ready response channel. It sits between the instruction-issue logic and the combinational ALU.

## Interface
- `MUL_LAT`, default 2: extra EXEC cycles for opcode 3'b010; legal range 0–7.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `req_valid` input, 2: bit i asserts a pending request from requester i.
- `req_ready` output, 2: bit i is a one-cycle accept of requester i.
- `req_a` input, 2×5: operand A per requester.
- `req_b` input, 2×5: operand B per requester.
- `req_op` input, 2×3: opcode per requester.
- `rsp_valid` output, 1: result is available.
- `rsp_ready` input, 1: consumer accepts the result.
- `rsp_id` output, 1: index of the requester that owns the result.
- `rsp_result` output, 10: the ALU result.
- `busy` output, 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE → EXEC when any `req_valid` is high.
  - EXEC → RESP when the execute counter reaches 0.
  - RESP → IDLE on `rsp_valid & rsp_ready`.
- Arbitration (IDLE only):
  - Exactly one granted requester sees `req_ready` high, combinationally from `req_valid` and the priority pointer.
  - If one requester is valid, that requester is granted.
  - If both are valid, the requester not granted last is granted.
  - The pointer updates only on accept.
- On accept, the block latches a, b, opcode and the id. Requesters must hold their inputs stable while `valid & !ready`. Requesters must not drop `valid` before `ready`.
- EXEC counter:
  - Loaded on accept with `MUL_LAT` for opcode 010, otherwise 0.
  - Decrements each EXEC cycle.
  - The result is registered in the final EXEC cycle.
- Result rules (unsigned, zero-extended to 10 bits):
  - 000 add: 6-bit a+b.
  - 001 sub: (a−b) mod 64, 6-bit.
  - 010 mul: 10-bit a·b.
  - 011/100/101 and/xor/or: 5-bit.
  - 110 ×2: 6-bit a<<1.
  - 111 ÷2: 4-bit a>>1.
- `rsp_id`, `rsp_result` and `rsp_valid` are held stable in RESP until accepted. New requests are not accepted while in EXEC or RESP.

## Timing
- Reset values:
  - state IDLE, pointer = 1 (requester 0 wins the first tie).
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `busy` = 0.
  - Counters cleared.
- Latency from the accept cycle T to `rsp_valid`:
  - T+2 for non-multiply ops.
  - T+2+`MUL_LAT` for multiply.
- Minimum spacing between accepts: 3 cycles (non-mul, `rsp_ready` held high). Handshake cycle in RESP → IDLE at the next edge → next accept possible in that IDLE cycle.
- `rsp_ready` held low: the block stays in RESP indefinitely and `req_ready` stays 0.
- Reset asserted mid-EXEC or mid-RESP: the in-flight op is discarded and no response is issued. Outputs return to reset values asynchronously.
- `req_valid` rising in the same cycle as the RESP→IDLE handshake: not accepted until the following (IDLE) cycle.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - Adds outputs `grant_cnt0` and `grant_cnt1` (16-bit each), incremented on each accept of the respective requester.
  - Both wrap 0xFFFF → 0 and reset to 0.
- Not defined: the ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Package `alu_pkg`:
  - Opcode enum (`OP_ADD`…`OP_DIV2`).
  - Widths `OPND_W` = 5, `RES_W` = 10.
  - FSM state enum.
- Sub-module `alu_core`: the purely combinational ALU (a, b, opcode → 10-bit result), instantiated once and fed from the latched operands. The arbiter and FSM live in `alu_arb_sched`.

## Test plan
- Requester 0 only: a=7, b=9, op=000 → accepted at T, `rsp_valid` at T+2, `rsp_result`=16, `rsp_id`=0.
- Sub wrap: a=3, b=5, op=001 → `rsp_result`=62 (0x03E).
- Multiply with `MUL_LAT`=2: a=31, b=31, op=010 → `rsp_valid` at T+4, `rsp_result`=961.
- Both requesters valid continuously (op 110, a=20 / a=11), `rsp_ready`=1:
  - Grants alternate 0,1,0,1.
  - Results 40 and 22.
  - Accepts spaced 3 cycles apart.
- Backpressure: `rsp_ready`=0 for 5 cycles with op 111, a=17 → `rsp_result`=8 held stable, `req_ready`=0 throughout, then one handshake and return to IDLE.
- Reset mid-EXEC of a multiply → `busy`=0 and no `rsp_valid` afterwards. The next request from requester 0 is granted first. With `ALU_ARB_STATS_EN`, counters read 0 after reset and 1 after that grant.
